// File: rtl/mau_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mau_pkg : size encodings, FSM state type and byte-count helper       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package mau_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        ISSUE = 3'd2,
        GAP   = 3'd3,
        DONE  = 3'd4
    } mau_state_t;

    function automatic logic [3:0] byte_count(input logic [1:0] size);
        return 4'd1 << size;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mau_byte_lane.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mau_byte_lane : big-endian byte extract/insert and read extension    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module mau_byte_lane #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [DATA_W-1:0] i_acc,
    input  logic [2:0]        i_idx,
    input  logic [3:0]        i_nbytes,
    input  logic [7:0]        i_rbyte,
    input  logic              i_sext,
    output logic [7:0]        o_wbyte,
    output logic [DATA_W-1:0] o_acc,
    output logic [DATA_W-1:0] o_ext
);
    localparam int NL = DATA_W / 8;

    logic [3:0] w_lane;
    logic [6:0] w_nbits;
    logic       w_sign;

    // Byte 0 of a transfer is the most significant byte of the value.
    assign w_lane  = i_nbytes - 4'd1 - {1'b0, i_idx};
    assign w_nbits = {i_nbytes, 3'b000};

    always_comb begin
        o_wbyte = 8'h00;
        o_acc   = i_acc;
        for (int l = 0; l < NL; l++) begin
            if (w_lane == 4'(l)) begin
                o_wbyte          = i_wdata[8*l +: 8];
                o_acc[8*l +: 8]  = i_rbyte;
            end
        end
    end

    always_comb begin
        w_sign = 1'b0;
        for (int l = 0; l < NL; l++) begin
            if (i_nbytes == 4'(l + 1)) begin
                w_sign = o_acc[8*l + 7];
            end
        end
    end

    always_comb begin
        o_ext = '0;
        for (int b = 0; b < DATA_W; b++) begin
            o_ext[b] = (7'(b) < w_nbits) ? o_acc[b] : (i_sext & w_sign);
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_access_unit : byte-serial byte/half/word memory access engine.   |
// | Define MAU_TIMEOUT_EN to add a per-byte mem_mfc timeout.             |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module mem_access_unit #(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 9,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              Clk,
    input  logic              reset,
    input  logic              req,
    input  logic              rw,
    input  logic [1:0]        size,
    input  logic              sext,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_mfa,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_mfc
);
    import mau_pkg::*;

    localparam int MAX_BYTES = DATA_W / 8;

    mau_state_t        r_state;
    logic [ADDR_W-1:0] r_base;
    logic              r_rw;
    logic              r_sext;
    logic [1:0]        r_size;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_acc;
    logic [2:0]        r_idx;
    logic              r_busy;
    logic              r_done;
    logic              r_err;
    logic [DATA_W-1:0] r_rdata;
    logic              r_mfa;
    logic              r_mem_rw;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [7:0]        r_mem_wdata;

`ifdef MAU_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0]  r_tmo;
`endif

    logic [3:0]        w_nbytes;
    logic              w_bad;
    logic              w_last;
    logic [ADDR_W-1:0] w_byte_addr;
    logic [7:0]        w_wbyte;
    logic [DATA_W-1:0] w_acc_ins;
    logic [DATA_W-1:0] w_ext;

    assign w_nbytes    = byte_count(r_size);
    assign w_bad       = (r_size == SZ_RSVD)
                      || ((r_size == SZ_HALF) && r_base[0])
                      || ((r_size == SZ_WORD) && (r_base[1:0] != 2'b00))
                      || (int'(w_nbytes) > MAX_BYTES);
    assign w_last      = ({1'b0, r_idx} == (w_nbytes - 4'd1));
    assign w_byte_addr = r_base + ADDR_W'(r_idx);

    mau_byte_lane #(
        .DATA_W (DATA_W)
    ) u_lane (
        .i_wdata  (r_wdata),
        .i_acc    (r_acc),
        .i_idx    (r_idx),
        .i_nbytes (w_nbytes),
        .i_rbyte  (mem_rdata),
        .i_sext   (r_sext),
        .o_wbyte  (w_wbyte),
        .o_acc    (w_acc_ins),
        .o_ext    (w_ext)
    );

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_base      <= '0;
            r_rw        <= 1'b1;
            r_sext      <= 1'b0;
            r_size      <= SZ_BYTE;
            r_wdata     <= '0;
            r_acc       <= '0;
            r_idx       <= 3'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_rdata     <= '0;
            r_mfa       <= 1'b0;
            r_mem_rw    <= 1'b1;
            r_mem_addr  <= '0;
            r_mem_wdata <= 8'h00;
`ifdef MAU_TIMEOUT_EN
            r_tmo       <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req) begin
                        r_base  <= addr;
                        r_rw    <= rw;
                        r_size  <= size;
                        r_sext  <= sext;
                        r_wdata <= wdata;
                        r_idx   <= 3'd0;
                        r_acc   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= CHECK;
                    end
                end
                CHECK: begin
                    if (w_bad) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_err   <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_mfa       <= 1'b1;
                        r_mem_rw    <= r_rw;
                        r_mem_addr  <= w_byte_addr;
                        r_mem_wdata <= w_wbyte;
`ifdef MAU_TIMEOUT_EN
                        r_tmo       <= '0;
`endif
                        r_state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (mem_mfc) begin
                        r_mfa <= 1'b0;
                        if (r_rw) begin
                            r_acc <= w_acc_ins;
                        end
                        if (w_last) begin
                            if (r_rw) begin
                                r_rdata <= w_ext;
                            end
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_idx   <= r_idx + 3'd1;
                            r_state <= GAP;
                        end
                    end
`ifdef MAU_TIMEOUT_EN
                    else if (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                        r_mfa   <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_err   <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
`endif
                end
                GAP: begin
                    // r_idx already points at the next byte here.
                    r_mfa       <= 1'b1;
                    r_mem_addr  <= w_byte_addr;
                    r_mem_wdata <= w_wbyte;
`ifdef MAU_TIMEOUT_EN
                    r_tmo       <= '0;
`endif
                    r_state     <= ISSUE;
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_mfa   <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
    assign rdata     = r_rdata;
    assign mem_mfa   = r_mfa;
    assign mem_rw    = r_mem_rw;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule
`default_nettype wire

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 32, CPU data width; must be a multiple of 8, range 8..64.
REQ-002 SHALL have parameter ADDR_W, default 9, byte-address width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 16, maximum wait for mem_mfc per byte (used only with MAU_TIMEOUT_EN).
REQ-004 SHALL have ports:
- Clk  in  1  rising-edge clock; the block's one clock.
- reset  in  1  asynchronous, active-low reset.
- req  in  1  access request, sampled in IDLE only.
- rw  in  1  1 = read, 0 = write.
- size  in  2  00 byte, 01 halfword, 10 word, 11 reserved.
- sext  in  1  sign-extend read data.
- addr  in  ADDR_W  byte address.
- wdata  in  DATA_W  write data; the value sits in the low bytes.
- busy  out  1  access in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  error flag, valid while done is high.
- rdata  out  DATA_W  read result, held until the next done.
- mem_mfa  out  1  memory function active.
- mem_rw  out  1  memory direction, same encoding as rw.
- mem_addr  out  ADDR_W  memory byte address.
- mem_wdata  out  8  memory write byte.
- mem_rdata  in  8  memory read byte.
- mem_mfc  in  1  memory function complete.

Function
REQ-005 SHALL use FSM states IDLE, CHECK, ISSUE, GAP, DONE.
REQ-006 SHALL, in IDLE with req=1, latch addr, rw, size, sext and wdata, and enter CHECK; req in any other state SHALL be ignored.
REQ-007 SHALL, in CHECK, go to DONE with err=1 and no memory cycle on any of:
- size=11;
- size=01 with addr[0]≠0;
- size=10 with addr[1:0]≠0;
- byte count 2^size > DATA_W/8.
Otherwise it SHALL go to ISSUE.
REQ-008 SHALL transfer N=2^size bytes, index i=0..N-1, with mem_addr = base+i modulo 2^ADDR_W.
REQ-009 SHALL order bytes big-endian: byte i maps to value bits [8*(N-1-i)+7 : 8*(N-1-i)].
REQ-010 SHALL, in ISSUE, hold mem_mfa=1 with stable mem_addr, mem_rw and mem_wdata until mem_mfc is sampled high.
REQ-011 SHALL, on a read, capture mem_rdata in the same cycle mem_mfc is sampled high.
REQ-012 SHALL, after a non-last byte, spend exactly one GAP cycle with mem_mfa=0, then return to ISSUE; after the last byte it SHALL go to DONE.
REQ-013 SHALL, in DONE, assert done for exactly one cycle and then return to IDLE.
REQ-014 SHALL, on a successful read, update rdata in the DONE cycle, zero-extended (sext=0) or sign-extended from bit 8N-1 (sext=1); writes and errors SHALL leave rdata unchanged.
REQ-015 SHALL drive busy=1 in CHECK, ISSUE and GAP, and busy=0 in IDLE and DONE.
REQ-016 SHALL drive mem_mfa=0 in all states other than ISSUE.
REQ-017 SHALL give a per-byte cost of W+1 ISSUE cycles (mem_mfc high W cycles after mem_mfa rises) plus one GAP or DONE cycle.

Reset
REQ-018 SHALL, while reset=0, force immediately (asynchronously) IDLE, busy=0, done=0, err=0, mem_mfa=0, mem_rw=1, mem_addr=0, mem_wdata=0, rdata=0.
REQ-019 SHALL abort any in-flight access on reset with no done pulse; partial write bytes already issued remain in memory.

Configuration
REQ-020 SHALL, with macro MAU_TIMEOUT_EN defined, count ISSUE cycles per byte; after TIMEOUT_CYCLES cycles without mem_mfc it SHALL drop mem_mfa and go to DONE with err=1.
REQ-021 SHALL, without MAU_TIMEOUT_EN, wait for mem_mfc indefinitely, contain no timeout counter, and ignore TIMEOUT_CYCLES.

Structure
REQ-022 SHALL take from shared package mau_pkg: the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), the FSM state typedef, and the byte-count function.
REQ-023 SHALL place byte-lane selection (write byte extract, read byte insert, extension) in sub-module mau_byte_lane.

Verification
REQ-024 SHALL cover: word write 0xDEADBEEF to 0x010, mem_mfc one cycle after mem_mfa -> bytes DE,AD,BE,EF at 0x010..0x013; done 12 cycles after req is sampled; err=0.
REQ-025 SHALL cover: byte read at 0x005 returning 0x80, sext=1 -> rdata 0xFFFFFF80; repeated with sext=0 -> rdata 0x00000080.
REQ-026 SHALL cover: halfword read at 0x003 -> mem_mfa never asserted; done one cycle after CHECK with err=1; rdata unchanged.
REQ-027 SHALL cover: MAU_TIMEOUT_EN defined, TIMEOUT_CYCLES=16, mem_mfc held low -> mem_mfa high exactly 16 cycles, then done with err=1.
REQ-028 SHALL cover: reset=0 during the second byte of a word read -> mem_mfa=0 and busy=0 immediately, no done; the next request completes normally.
REQ-029 SHALL cover: req held high through an access -> exactly one access per IDLE sample; back-to-back halfword reads at 0x000 and 0x002 both correct.
